// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM SRAM port arbiter: FSM states, owner ids, default latency.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_LEN = 2;

  typedef enum logic [ARB_STATE_LEN-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_IF  = 1'b0;
  localparam logic ARB_OWNER_MEM = 1'b1;

  localparam int SRAM_WAIT_CYCLES = 3;
  localparam int CNT_W            = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_state_counter.sv
// Wait-state down-counter: loads on grant, decrements while the access runs; saturates at zero.
// Zero flag marks the last BUSY cycle, on which SRAM read data is valid.
module mem_port_arbiter_wait_state_counter
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM between IF and MEM; ready pulses WAIT_CYCLES+1 cycles after grant.
// Requesters are stalled until their ready strobe; on contention the previous owner yields.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_en,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              if_stall,
  output logic              pipe_stall
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state, state_nxt;
  logic              owner, last_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;
  logic              mem_req, grant_mem;
  logic              start, capture;

  assign mem_req = mem_r_en | mem_w_en;

  // Contention goes to whoever did not own the last completed access.
  always_comb begin
    grant_mem = mem_req;
    if (if_req && mem_req) begin
      grant_mem = (last_owner == ARB_OWNER_IF);
    end
  end

  mem_port_arbiter_wait_state_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .load_val (CNT_LOAD),
    .dec      (state == ARB_BUSY),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SRAM strobes decode straight from state so an async reset kills them without a clock.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    capture   = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (if_req || mem_req) begin
          start     = 1'b1;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        sram_en = 1'b1;
        sram_we = we_q;
        if (cnt_zero) begin
          capture   = 1'b1;
          state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if_ready  = (owner == ARB_OWNER_IF);
        mem_ready = (owner == ARB_OWNER_MEM);
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= ARB_OWNER_IF;
      last_owner <= ARB_OWNER_MEM;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if (start) begin
        owner   <= grant_mem;
        addr_q  <= grant_mem ? mem_addr : if_addr;
        wdata_q <= grant_mem ? mem_wdata : '0;
        we_q    <= grant_mem & mem_w_en;
      end
      if (capture) begin
        last_owner <= owner;
        if (owner == ARB_OWNER_IF) begin
          if_rdata <= sram_rdata;
        end else if (!we_q) begin
          mem_rdata <= sram_rdata;
        end
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_stall   = if_req & ~if_ready;
  assign pipe_stall = mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance A at 3 wait states, instance B at 1 wait state, sharing one SRAM model.
module tb_mem_port_arbiter;

  localparam int WAIT_A = 3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          unexp_pulses = 0;
  int          pulses = 0;
  int          b_if_pulses = 0;
  exp_t        a_if_q[$], a_mem_q[$], b_mem_q[$];
  exp_t        e_mon;
  logic [31:0] mem [0:1023];

  logic        a_if_req, a_if_ready, a_mem_r_en, a_mem_w_en, a_mem_ready;
  logic        a_sram_we, a_sram_en, a_if_stall, a_pipe_stall;
  logic [31:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] a_sram_addr, a_sram_wdata, a_sram_rdata;
  logic        b_if_req, b_if_ready, b_mem_r_en, b_mem_w_en, b_mem_ready;
  logic        b_sram_we, b_sram_en, b_if_stall, b_pipe_stall;
  logic [31:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_sram_addr, b_sram_wdata, b_sram_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_sram_rdata = mem[a_sram_addr[11:2]];
  assign b_sram_rdata = mem[b_sram_addr[11:2]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .mem_r_en(a_mem_r_en), .mem_w_en(a_mem_w_en), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
    .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_we(a_sram_we),
    .sram_en(a_sram_en), .sram_rdata(a_sram_rdata),
    .if_stall(a_if_stall), .pipe_stall(a_pipe_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_we(b_sram_we),
    .sram_en(b_sram_en), .sram_rdata(b_sram_rdata),
    .if_stall(b_if_stall), .pipe_stall(b_pipe_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Ready monitor: every strobe must match the head of its queue in data and cycle.
  always @(negedge clk) begin
    if (a_if_ready) begin
      pulses++;
      if (a_if_q.size() == 0) unexp_pulses++;
      else begin
        e_mon = a_if_q.pop_front();
        check("a_if_rdata", a_if_rdata, e_mon.data);
        check("a_if_cycle", cyc, e_mon.cyc);
      end
    end
    if (a_mem_ready) begin
      pulses++;
      if (a_mem_q.size() == 0) unexp_pulses++;
      else begin
        e_mon = a_mem_q.pop_front();
        check("a_mem_rdata", a_mem_rdata, e_mon.data);
        check("a_mem_cycle", cyc, e_mon.cyc);
      end
    end
    if (b_mem_ready) begin
      if (b_mem_q.size() == 0) unexp_pulses++;
      else begin
        e_mon = b_mem_q.pop_front();
        check("b_mem_rdata", b_mem_rdata, e_mon.data);
        check("b_mem_cycle", cyc, e_mon.cyc);
      end
    end
    if (b_if_ready) b_if_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_a();
    a_if_req = 1'b0; a_mem_r_en = 1'b0; a_mem_w_en = 1'b0;
  endtask

  // Single access on A, entered just after a rising edge; checks SRAM strobes and stalls per cycle.
  task automatic run_single(input logic is_mem, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data);
    int   n;
    logic busy;
    exp_t e;
    n = cyc;
    e.data = exp_data;
    e.cyc  = n + WAIT_A + 1;
    if (is_mem) begin
      a_mem_r_en = ~we; a_mem_w_en = we; a_mem_addr = addr; a_mem_wdata = wdata;
      a_mem_q.push_back(e);
    end else begin
      a_if_req = 1'b1; a_if_addr = addr;
      a_if_q.push_back(e);
    end
    for (int k = 0; k <= WAIT_A + 1; k++) begin
      @(negedge clk);
      busy = (k >= 1) && (k <= WAIT_A);
      check("a_sram_en", a_sram_en, busy);
      check("a_sram_we", a_sram_we, busy & we);
      if (busy) check("a_sram_addr", a_sram_addr, addr);
      if (busy && we) check("a_sram_wdata", a_sram_wdata, wdata);
      check("a_if_stall", a_if_stall, !is_mem && (k <= WAIT_A));
      check("a_pipe_stall", a_pipe_stall, is_mem && (k <= WAIT_A));
    end
    tick();
    drop_a();
  endtask

  // IF fetch and MEM load raised together; first winner ready at +4, second at +9.
  task automatic run_pair(input logic mem_first, input logic [31:0] if_a, input logic [31:0] mem_a,
                          input logic [31:0] if_d, input logic [31:0] mem_d);
    int   n;
    exp_t e;
    n = cyc;
    a_if_req = 1'b1; a_if_addr = if_a;
    a_mem_r_en = 1'b1; a_mem_addr = mem_a;
    e.data = if_d;  e.cyc = n + (mem_first ? 2 * WAIT_A + 3 : WAIT_A + 1); a_if_q.push_back(e);
    e.data = mem_d; e.cyc = n + (mem_first ? WAIT_A + 1 : 2 * WAIT_A + 3); a_mem_q.push_back(e);
    for (int k = 0; k <= 2 * WAIT_A + 3; k++) begin
      @(negedge clk);
      if (k <= WAIT_A) check("pair_both_stall", a_if_stall & a_pipe_stall, 1'b1);
      if (k == WAIT_A + 1 || k == 2 * WAIT_A + 3) begin
        tick();
        if ((k == WAIT_A + 1) == mem_first) a_mem_r_en = 1'b0;
        else a_if_req = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]   = 32'hE3A01005;
    mem[257] = 32'h0BADF00D;
    mem[8]   = 32'hA0A0A0A0;
    mem[12]  = 32'hC0C0C0C0;
    mem[16]  = 32'h55AA55AA;
    mem[17]  = 32'h77777777;
    mem[18]  = 32'h88888888;
    mem[2]   = 32'h12345678;
    drop_a();
    a_if_addr = '0; a_mem_addr = '0; a_mem_wdata = '0;
    b_if_req = 1'b0; b_mem_r_en = 1'b0; b_mem_w_en = 1'b0;
    b_if_addr = '0; b_mem_addr = '0; b_mem_wdata = '0;

    repeat (3) tick();
    check("rst_sram_en", a_sram_en, 1'b0);
    check("rst_sram_we", a_sram_we, 1'b0);
    check("rst_if_ready", a_if_ready, 1'b0);
    check("rst_mem_ready", a_mem_ready, 1'b0);
    check("rst_if_rdata", a_if_rdata, 32'h0);
    check("rst_mem_rdata", a_mem_rdata, 32'h0);
    check("rst_sram_addr", a_sram_addr, 32'h0);
    check("rst_b_sram_en", b_sram_en, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    check("idle_sram_en", a_sram_en, 1'b0);
    check("idle_stall", a_if_stall | a_pipe_stall, 1'b0);

    run_single(1'b0, 1'b0, 32'h10, 32'h0, 32'hE3A01005);
    run_single(1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0);
    run_single(1'b1, 1'b0, 32'h404, 32'h0, 32'h0BADF00D);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst2_mem_rdata", a_mem_rdata, 32'h0);
    run_pair(1'b0, 32'h20, 32'h30, 32'hA0A0A0A0, 32'hC0C0C0C0);
    run_single(1'b0, 1'b0, 32'h40, 32'h0, 32'h55AA55AA);
    run_pair(1'b1, 32'h44, 32'h48, 32'h77777777, 32'h88888888);

    // Abort a store in its second BUSY cycle with no clock edge in between.
    n = cyc;
    a_mem_w_en = 1'b1; a_mem_addr = 32'h500; a_mem_wdata = 32'h1;
    repeat (3) @(negedge clk);
    check("abort_we_before", a_sram_we, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_we_async", a_sram_we, 1'b0);
    check("abort_en_async", a_sram_en, 1'b0);
    check("abort_no_edge", cyc, n + 2);
    drop_a();
    tick();
    rst = 1'b1;
    n = pulses;
    repeat (6) tick();
    check("abort_no_ready", pulses, n);
    check("abort_idle_en", a_sram_en, 1'b0);

    // One wait state: held load is re-granted after DONE+IDLE and re-reads the SRAM.
    n = cyc;
    b_mem_r_en = 1'b1; b_mem_addr = 32'h8;
    e_push_b(32'h12345678, n + 2);
    e_push_b(32'hCAFEF00D, n + 5);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("b_sram_en", b_sram_en, (k == 1) || (k == 4));
      check("b_pipe_stall", b_pipe_stall, (k != 2) && (k != 5));
      if (k == 2) mem[2] = 32'hCAFEF00D;
    end
    tick();
    b_mem_r_en = 1'b0;
    repeat (3) tick();

    check("a_if_drain", a_if_q.size(), 0);
    check("a_mem_drain", a_mem_q.size(), 0);
    check("b_mem_drain", b_mem_q.size(), 0);
    check("unexpected_ready", unexp_pulses, 0);
    check("b_if_pulses", b_if_pulses, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic e_push_b(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    b_mem_q.push_back(e);
  endtask

endmodule
